// File: rtl/wramp_io_pkg.sv
// ============================================================================
// Module   : wramp_io_pkg
// Purpose  : Shared constants, register offsets and FSM state types for the
//            wramp memory-port I/O bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wramp_io_pkg;

  localparam logic [19:0] HALT_ADDR  = 20'hfffff;
  localparam logic [31:0] HALT_MAGIC = 32'h0000dead;

  typedef enum logic [3:0] {
    REG_TXDATA  = 4'd0,
    REG_STATUS  = 4'd1,
    REG_DIVISOR = 4'd2,
    REG_RXDATA  = 4'd3
  } reg_off_t;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_TX_IDLE  = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_RX_VALID = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A zero divisor would stall the bit counters, so it is stored as one.
  function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
    return (value == 16'd0) ? 16'd1 : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wramp_sync_fifo.sv
// ============================================================================
// Module   : wramp_sync_fifo
// Purpose  : Count-based synchronous FIFO; push is accepted when full if a
//            pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wramp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_COUNT);
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign rdata_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/wramp_io_bridge.sv
// ============================================================================
// Module   : wramp_io_bridge
// Purpose  : Decodes wramp core memory accesses to RAM, an 8N1 serial port
//            with TX FIFO, or a simulation-halt register.
//            Optional receiver enabled by defining WRAMP_IO_RX_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wramp_io_bridge
  import wramp_io_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16,
  parameter logic [19:0] IO_BASE     = 20'h70000
) (
  input  logic        clk,
  input  logic        rst_async,
  input  logic [19:0] mem_address,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_value,
  output logic [31:0] mem_read_value,
  output logic [15:0] ram_address,
  output logic        ram_write_en,
  output logic [31:0] ram_write_value,
  input  logic [31:0] ram_read_value,
  output logic        tx,
  output logic        sim_done
`ifdef WRAMP_IO_RX_EN
  ,
  input  logic        rx
`endif
);

  logic        w_ram_hit;
  logic        w_io_hit;
  logic        w_halt_hit;
  logic [3:0]  w_io_off;
  logic        w_io_wr;
  logic        w_push;
  logic        w_fifo_pop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_rdata;
  logic        w_tx_idle;
  logic [15:0] w_reload;
  logic        w_rx_valid;
  logic        w_rx_ovf_set;
  logic [7:0]  w_rx_data;

  logic [15:0] divisor_q;
  logic        overflow_q;
  logic        sim_done_q;
  tx_state_t   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;

  // The serial block occupies 16 words; IO_BASE is assumed 16-word aligned.
  assign w_ram_hit  = (mem_address[19:16] == 4'h0);
  assign w_io_hit   = (mem_address[19:4] == IO_BASE[19:4]);
  assign w_halt_hit = (mem_address == HALT_ADDR);
  assign w_io_off   = mem_address[3:0];
  assign w_io_wr    = mem_write_en & w_io_hit;
  assign w_push     = w_io_wr & (w_io_off == REG_TXDATA);

  assign ram_address     = mem_address[15:0];
  assign ram_write_en    = mem_write_en & w_ram_hit;
  assign ram_write_value = mem_write_value;

  assign tx       = tx_q;
  assign sim_done = sim_done_q;

  assign w_reload   = divisor_q - 16'd1;
  assign w_tx_idle  = w_fifo_empty & (tx_state_q == TX_IDLE);
  assign w_fifo_pop = ~w_fifo_empty &
                      ((tx_state_q == TX_IDLE) ||
                       ((tx_state_q == TX_STOP) && (tx_cnt_q == 16'd0)));

  wramp_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_async (rst_async),
    .push_i    (w_push),
    .wdata_i   (mem_write_value[7:0]),
    .pop_i     (w_fifo_pop),
    .rdata_o   (w_fifo_rdata),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty)
  );

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      divisor_q  <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      sim_done_q <= 1'b0;
    end else begin
      if (w_io_wr && (w_io_off == REG_DIVISOR)) begin
        divisor_q <= clamp_divisor(mem_write_value[15:0]);
      end
      if ((w_push && w_fifo_full && !w_fifo_pop) || w_rx_ovf_set) begin
        overflow_q <= 1'b1;
      end else if (w_io_wr && (w_io_off == REG_STATUS)) begin
        overflow_q <= 1'b0;
      end
      if (mem_write_en && w_halt_hit && (mem_write_value == HALT_MAGIC)) begin
        sim_done_q <= 1'b1;
      end
    end
  end

  // Each state holds for divisor_q clocks; the divisor is only sampled on reload.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!w_fifo_empty) begin
            tx_state_q <= TX_START;
            tx_shift_q <= w_fifo_rdata;
            tx_cnt_q   <= w_reload;
            tx_q       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_q == 16'd0) begin
            tx_state_q <= TX_DATA;
            tx_q       <= tx_shift_q[0];
            tx_cnt_q   <= w_reload;
            tx_bit_q   <= 3'd0;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= w_reload;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == 16'd0) begin
            if (!w_fifo_empty) begin
              tx_state_q <= TX_START;
              tx_shift_q <= w_fifo_rdata;
              tx_cnt_q   <= w_reload;
              tx_q       <= 1'b0;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

`ifdef WRAMP_IO_RX_EN
  logic [1:0]  rx_sync_q;
  rx_state_t   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        w_rx_rd_clr;
  logic        w_rx_done;

  // The core bus has no read strobe, so an address sitting on RXDATA is a read.
  assign w_rx_rd_clr  = w_io_hit & ~mem_write_en & (w_io_off == REG_RXDATA);
  assign w_rx_done    = (rx_state_q == RX_STOP) && (rx_cnt_q == 16'd0) && rx_sync_q[1];
  assign w_rx_ovf_set = w_rx_done & rx_valid_q & ~w_rx_rd_clr;
  assign w_rx_valid   = rx_valid_q;
  assign w_rx_data    = rx_data_q;

  // Half-bit delay is shortened by one to absorb the synchroniser latency.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
      if (w_rx_rd_clr) rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q[1]) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= {1'b0, w_reload[15:1]};
          end
        end
        RX_START: begin
          if (rx_cnt_q == 16'd0) begin
            if (!rx_sync_q[1]) begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= w_reload;
              rx_bit_q   <= 3'd0;
            end else begin
              rx_state_q <= RX_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
            rx_cnt_q   <= w_reload;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == 16'd0) begin
            rx_state_q <= RX_IDLE;
            if (rx_sync_q[1]) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
`else
  assign w_rx_valid   = 1'b0;
  assign w_rx_ovf_set = 1'b0;
  assign w_rx_data    = 8'h00;
`endif

  always_comb begin
    mem_read_value = 32'h0;
    if (w_ram_hit) begin
      mem_read_value = ram_read_value;
    end else if (w_io_hit) begin
      case (w_io_off)
        REG_STATUS: begin
          mem_read_value[STAT_TX_READY] = ~w_fifo_full;
          mem_read_value[STAT_TX_IDLE]  = w_tx_idle;
          mem_read_value[STAT_OVERFLOW] = overflow_q;
          mem_read_value[STAT_RX_VALID] = w_rx_valid;
        end
        REG_DIVISOR: mem_read_value = {16'h0, divisor_q};
        REG_RXDATA:  mem_read_value = {24'h0, w_rx_data};
        default:     mem_read_value = 32'h0;
      endcase
    end
  end

endmodule

`default_nettype wire
